// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack port of
// arbitrary latency and presents one registered instruction to decode.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        IFwip,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFinst,
    output logic        IFvalid,
    output logic [31:0] IFpc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  issue_addr;
    logic [31:0]  target_pc;
    logic         consume;
    logic         space;
    logic         load;

    assign consume   = IFvalid & IFwip;
    assign space     = ~IFvalid | IFwip;
    assign target_pc = redirect_pc & ~32'h0000_0003;

    always_comb begin
        imem_req = 1'b0;
        case (state)
            IDLE:    imem_req = space & ~redirect;
            WAIT:    imem_req = 1'b1;
            DROP:    imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
        imem_req = imem_req & clrn;
    end

    // DROP keeps presenting the abandoned address because pc already holds
    // the redirect target.
    assign imem_addr = (state == DROP) ? issue_addr : pc;

    assign load = imem_ack & ~redirect &
                  (((state == IDLE) & space) | (state == WAIT));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            issue_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= target_pc;
                    end else if (space) begin
                        issue_addr <= pc;
                        if (imem_ack) begin
                            pc <= pc + 32'd4;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= target_pc;
                        state <= imem_ack ? IDLE : DROP;
                    end else if (imem_ack) begin
                        pc    <= pc + 32'd4;
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc <= target_pc;
                    end
                    if (imem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            IFinst  <= NOP_INST;
            IFvalid <= 1'b0;
            IFpc    <= '0;
        end else if (redirect) begin
            IFinst  <= NOP_INST;
            IFvalid <= 1'b0;
        end else if (load) begin
            IFinst  <= imem_rdata;
            IFvalid <= 1'b1;
            IFpc    <= pc;
        end else if (consume) begin
            IFinst  <= NOP_INST;
            IFvalid <= 1'b0;
        end
    end

endmodule
